// File: rtl/regfile_source_server.sv
// -----------------------------------------------------------------------------
// regfile_source_server
//
// Storage behind the source-stage operand read interface. Holds the
// architectural register file (ARF) and the physical result file (PRF) with
// one ready bit per physical entry.
//
// Ports (all packed per-port arrays, index = port number):
//   clk_i           clock
//   reset_i         synchronous active-high reset (clears ARF, PRF, ready)
//   src1_i/src2_i   architectural read indices        -> arf1_o/arf2_o
//   psrc1_i/psrc2_i physical read indices             -> prf1_o/prf2_o,
//                                                        prdy1_o/prdy2_o
//   wb_*_i          writeback: PRF[preg] <= data, ready <= 1
//   alloc_*_i       rename allocation: ready[preg] <= 0
//   commit_*_i      commit: ARF[areg] <= PRF[preg] (index 0 oldest)
//   flush_i         clears every ready bit, data kept
//
// Reads are combinational and see same-cycle writebacks and commits
// (bypass). Architectural register 0 always reads as zero.
// -----------------------------------------------------------------------------

// Protocol checker: flags illegal writeback/allocation combinations.
module regfile_source_server_chk #(
  parameter int WB_PORTS    = 4,
  parameter int ALLOC_PORTS = 4,
  parameter int PREG_W      = 6
) (
  input logic                             clk_i,
  input logic                             reset_i,
  input logic [WB_PORTS-1:0]              wb_valid_i,
  input logic [WB_PORTS-1:0][PREG_W-1:0]  wb_preg_i,
  input logic [ALLOC_PORTS-1:0]           alloc_valid_i,
  input logic [ALLOC_PORTS-1:0][PREG_W-1:0] alloc_preg_i
);

  logic wb_dup_s;
  logic alloc_wb_s;

  // Detect two writebacks to one entry and alloc/writeback to one entry.
  always_comb begin
    wb_dup_s   = 1'b0;
    alloc_wb_s = 1'b0;
    for (int a = 0; a < WB_PORTS; a++) begin
      for (int b = a + 1; b < WB_PORTS; b++) begin
        wb_dup_s = wb_dup_s | (wb_valid_i[a] & wb_valid_i[b] &
                               (wb_preg_i[a] == wb_preg_i[b]));
      end
      for (int c = 0; c < ALLOC_PORTS; c++) begin
        alloc_wb_s = alloc_wb_s | (wb_valid_i[a] & alloc_valid_i[c] &
                                   (wb_preg_i[a] == alloc_preg_i[c]));
      end
    end
  end

  a_no_dup_wb: assert property (@(posedge clk_i) disable iff (reset_i) !wb_dup_s);
  a_no_alloc_wb: assert property (@(posedge clk_i) disable iff (reset_i) !alloc_wb_s);

endmodule

module regfile_source_server #(
  parameter int READ_PORTS   = 8,
  parameter int WB_PORTS     = 4,
  parameter int COMMIT_PORTS = 4,
  parameter int ALLOC_PORTS  = 4,
  parameter int PREG_NUM     = 64,
  parameter int AREG_NUM     = 32,
  parameter int XLEN         = 64,
  parameter int PREG_W       = $clog2(PREG_NUM),
  parameter int AREG_W       = $clog2(AREG_NUM)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [READ_PORTS-1:0][AREG_W-1:0]    src1_i,
  input  logic [READ_PORTS-1:0][AREG_W-1:0]    src2_i,
  input  logic [READ_PORTS-1:0][PREG_W-1:0]    psrc1_i,
  input  logic [READ_PORTS-1:0][PREG_W-1:0]    psrc2_i,
  output logic [READ_PORTS-1:0][XLEN-1:0]      arf1_o,
  output logic [READ_PORTS-1:0][XLEN-1:0]      arf2_o,
  output logic [READ_PORTS-1:0][XLEN-1:0]      prf1_o,
  output logic [READ_PORTS-1:0][XLEN-1:0]      prf2_o,
  output logic [READ_PORTS-1:0]                prdy1_o,
  output logic [READ_PORTS-1:0]                prdy2_o,
  input  logic [WB_PORTS-1:0]                  wb_valid_i,
  input  logic [WB_PORTS-1:0][PREG_W-1:0]      wb_preg_i,
  input  logic [WB_PORTS-1:0][XLEN-1:0]        wb_data_i,
  input  logic [ALLOC_PORTS-1:0]               alloc_valid_i,
  input  logic [ALLOC_PORTS-1:0][PREG_W-1:0]   alloc_preg_i,
  input  logic [COMMIT_PORTS-1:0]              commit_valid_i,
  input  logic [COMMIT_PORTS-1:0][AREG_W-1:0]  commit_areg_i,
  input  logic [COMMIT_PORTS-1:0][PREG_W-1:0]  commit_preg_i,
  input  logic                                 flush_i
);

  logic [XLEN-1:0]     prf_q [PREG_NUM];
  logic [XLEN-1:0]     prf_d [PREG_NUM];
  logic [XLEN-1:0]     arf_q [AREG_NUM];
  logic [XLEN-1:0]     arf_d [AREG_NUM];
  logic [PREG_NUM-1:0] rdy_q;
  logic [PREG_NUM-1:0] rdy_d;

  // PRF data each commit port copies, already bypassed from writeback.
  logic [COMMIT_PORTS-1:0][XLEN-1:0] commit_data_s;

  // PRF data for an index: stored value unless a writeback targets it now.
  function automatic logic [XLEN-1:0] prf_pick(
    input logic [XLEN-1:0]                  stored,
    input logic [PREG_W-1:0]                idx,
    input logic [WB_PORTS-1:0]              v,
    input logic [WB_PORTS-1:0][PREG_W-1:0]  p,
    input logic [WB_PORTS-1:0][XLEN-1:0]    d
  );
    logic [XLEN-1:0] r;
    r = stored;
    for (int w = 0; w < WB_PORTS; w++) begin
      r = (v[w] && (p[w] == idx)) ? d[w] : r;
    end
    return r;
  endfunction

  // Ready flag for an index: stored flag or a writeback landing this cycle.
  function automatic logic rdy_pick(
    input logic                             stored,
    input logic [PREG_W-1:0]                idx,
    input logic [WB_PORTS-1:0]              v,
    input logic [WB_PORTS-1:0][PREG_W-1:0]  p
  );
    logic r;
    r = stored;
    for (int w = 0; w < WB_PORTS; w++) begin
      r = r | (v[w] & (p[w] == idx));
    end
    return r;
  endfunction

  // ARF data for an index: x0 is zero; otherwise the youngest matching
  // same-cycle commit (highest port) overrides the stored value.
  function automatic logic [XLEN-1:0] arf_pick(
    input logic [XLEN-1:0]                      stored,
    input logic [AREG_W-1:0]                    idx,
    input logic [COMMIT_PORTS-1:0]              v,
    input logic [COMMIT_PORTS-1:0][AREG_W-1:0]  a,
    input logic [COMMIT_PORTS-1:0][XLEN-1:0]    d
  );
    logic [XLEN-1:0] r;
    r = stored;
    for (int c = 0; c < COMMIT_PORTS; c++) begin
      r = (v[c] && (a[c] == idx)) ? d[c] : r;
    end
    return (idx == {AREG_W{1'b0}}) ? {XLEN{1'b0}} : r;
  endfunction

  // Commit source data with writeback bypass.
  always_comb begin
    for (int c = 0; c < COMMIT_PORTS; c++) begin
      commit_data_s[c] = prf_pick(prf_q[commit_preg_i[c]], commit_preg_i[c],
                                  wb_valid_i, wb_preg_i, wb_data_i);
    end
  end

  // Combinational read ports.
  always_comb begin
    for (int i = 0; i < READ_PORTS; i++) begin
      prf1_o[i]  = prf_pick(prf_q[psrc1_i[i]], psrc1_i[i], wb_valid_i, wb_preg_i, wb_data_i);
      prf2_o[i]  = prf_pick(prf_q[psrc2_i[i]], psrc2_i[i], wb_valid_i, wb_preg_i, wb_data_i);
      prdy1_o[i] = rdy_pick(rdy_q[psrc1_i[i]], psrc1_i[i], wb_valid_i, wb_preg_i);
      prdy2_o[i] = rdy_pick(rdy_q[psrc2_i[i]], psrc2_i[i], wb_valid_i, wb_preg_i);
      arf1_o[i]  = arf_pick(arf_q[src1_i[i]], src1_i[i], commit_valid_i, commit_areg_i, commit_data_s);
      arf2_o[i]  = arf_pick(arf_q[src2_i[i]], src2_i[i], commit_valid_i, commit_areg_i, commit_data_s);
    end
  end

  // Next state: writeback, then allocation (wins over writeback ready),
  // then flush (wins over everything ready), then commits in port order.
  always_comb begin
    prf_d = prf_q;
    arf_d = arf_q;
    rdy_d = rdy_q;
    for (int w = 0; w < WB_PORTS; w++) begin
      prf_d[wb_preg_i[w]] = wb_valid_i[w] ? wb_data_i[w] : prf_d[wb_preg_i[w]];
      rdy_d[wb_preg_i[w]] = rdy_d[wb_preg_i[w]] | wb_valid_i[w];
    end
    for (int a = 0; a < ALLOC_PORTS; a++) begin
      rdy_d[alloc_preg_i[a]] = rdy_d[alloc_preg_i[a]] & ~alloc_valid_i[a];
    end
    rdy_d = flush_i ? {PREG_NUM{1'b0}} : rdy_d;
    for (int c = 0; c < COMMIT_PORTS; c++) begin
      arf_d[commit_areg_i[c]] =
        (commit_valid_i[c] && (commit_areg_i[c] != {AREG_W{1'b0}})) ?
        commit_data_s[c] : arf_d[commit_areg_i[c]];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int p = 0; p < PREG_NUM; p++) begin
        prf_q[p] <= {XLEN{1'b0}};
      end
      for (int r = 0; r < AREG_NUM; r++) begin
        arf_q[r] <= {XLEN{1'b0}};
      end
      rdy_q <= {PREG_NUM{1'b0}};
    end else begin
      prf_q <= prf_d;
      arf_q <= arf_d;
      rdy_q <= rdy_d;
    end
  end

  regfile_source_server_chk #(
    .WB_PORTS    (WB_PORTS),
    .ALLOC_PORTS (ALLOC_PORTS),
    .PREG_W      (PREG_W)
  ) u_chk (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .wb_valid_i    (wb_valid_i),
    .wb_preg_i     (wb_preg_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_preg_i  (alloc_preg_i)
  );

endmodule

// File: tb/tb_regfile_source_server.sv
module tb_regfile_source_server;

  localparam int RP = 8;
  localparam int WP = 4;
  localparam int CP = 4;
  localparam int AP = 4;

  logic clk = 1'b0;
  logic reset;
  logic [RP-1:0][4:0]  src1, src2;
  logic [RP-1:0][5:0]  psrc1, psrc2;
  logic [RP-1:0][63:0] arf1, arf2, prf1, prf2;
  logic [RP-1:0]       prdy1, prdy2;
  logic [WP-1:0]       wb_valid;
  logic [WP-1:0][5:0]  wb_preg;
  logic [WP-1:0][63:0] wb_data;
  logic [AP-1:0]       alloc_valid;
  logic [AP-1:0][5:0]  alloc_preg;
  logic [CP-1:0]       commit_valid;
  logic [CP-1:0][4:0]  commit_areg;
  logic [CP-1:0][5:0]  commit_preg;
  logic                flush;

  always #5 clk = ~clk;

  regfile_source_server dut (
    .clk_i(clk), .reset_i(reset),
    .src1_i(src1), .src2_i(src2), .psrc1_i(psrc1), .psrc2_i(psrc2),
    .arf1_o(arf1), .arf2_o(arf2), .prf1_o(prf1), .prf2_o(prf2),
    .prdy1_o(prdy1), .prdy2_o(prdy2),
    .wb_valid_i(wb_valid), .wb_preg_i(wb_preg), .wb_data_i(wb_data),
    .alloc_valid_i(alloc_valid), .alloc_preg_i(alloc_preg),
    .commit_valid_i(commit_valid), .commit_areg_i(commit_areg),
    .commit_preg_i(commit_preg), .flush_i(flush)
  );

  // Reference state: plain arrays updated by the architectural rules.
  logic [63:0] prf_m [64];
  logic        rdy_m [64];
  logic [63:0] arf_m [32];

  typedef struct packed {
    logic [RP-1:0][63:0] a1, a2, p1, p2;
    logic [RP-1:0]       r1, r2;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [63:0] prf_now(input logic [5:0] p);
    logic [63:0] r = prf_m[p];
    for (int w = 0; w < WP; w++) if (wb_valid[w] && wb_preg[w] == p) r = wb_data[w];
    return r;
  endfunction

  function automatic logic rdy_now(input logic [5:0] p);
    logic r = rdy_m[p];
    for (int w = 0; w < WP; w++) if (wb_valid[w] && wb_preg[w] == p) r = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] arf_now(input logic [4:0] a);
    logic [63:0] r;
    if (a == 5'd0) return 64'd0;
    r = arf_m[a];
    for (int c = 0; c < CP; c++)
      if (commit_valid[c] && commit_areg[c] == a) r = prf_now(commit_preg[c]);
    return r;
  endfunction

  task automatic clear_model();
    for (int p = 0; p < 64; p++) begin prf_m[p] = 64'd0; rdy_m[p] = 1'b0; end
    for (int a = 0; a < 32; a++) arf_m[a] = 64'd0;
  endtask

  task automatic apply_edge();
    logic [63:0] cd [CP];
    if (reset) begin
      clear_model();
    end else begin
      for (int c = 0; c < CP; c++) cd[c] = prf_now(commit_preg[c]);
      for (int w = 0; w < WP; w++)
        if (wb_valid[w]) begin prf_m[wb_preg[w]] = wb_data[w]; rdy_m[wb_preg[w]] = 1'b1; end
      for (int a = 0; a < AP; a++) if (alloc_valid[a]) rdy_m[alloc_preg[a]] = 1'b0;
      if (flush) for (int p = 0; p < 64; p++) rdy_m[p] = 1'b0;
      for (int c = 0; c < CP; c++)
        if (commit_valid[c] && commit_areg[c] != 5'd0) arf_m[commit_areg[c]] = cd[c];
    end
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0;
    wb_valid = '0; wb_preg = '0; wb_data = '0;
    alloc_valid = '0; alloc_preg = '0;
    commit_valid = '0; commit_areg = '0; commit_preg = '0;
    src1 = '0; src2 = '0; psrc1 = '0; psrc2 = '0;
  endtask

  // Push the expected read results for the current inputs, then clock.
  task automatic step();
    exp_t e;
    for (int i = 0; i < RP; i++) begin
      e.a1[i] = arf_now(src1[i]);  e.a2[i] = arf_now(src2[i]);
      e.p1[i] = prf_now(psrc1[i]); e.p2[i] = prf_now(psrc2[i]);
      e.r1[i] = rdy_now(psrc1[i]); e.r2[i] = rdy_now(psrc2[i]);
    end
    sb_q.push_back(e);
    @(posedge clk);
    apply_edge();
    #1;
  endtask

  task automatic rand_inputs();
    int base;
    reset = ($urandom_range(0, 59) == 0);
    flush = ($urandom_range(0, 19) == 0);
    base = $urandom_range(0, 63);
    for (int w = 0; w < WP; w++) begin
      wb_valid[w] = 1'($urandom_range(0, 1));
      wb_preg[w]  = 6'(base + w * 16);
      wb_data[w]  = {$urandom(), $urandom()};
    end
    for (int a = 0; a < AP; a++) begin
      alloc_valid[a] = ($urandom_range(0, 3) == 0);
      alloc_preg[a]  = 6'($urandom_range(0, 63));
      for (int w = 0; w < WP; w++)
        if (wb_valid[w] && wb_preg[w] == alloc_preg[a]) alloc_valid[a] = 1'b0;
    end
    for (int c = 0; c < CP; c++) begin
      commit_valid[c] = 1'($urandom_range(0, 1));
      commit_areg[c]  = 5'($urandom_range(0, 7));
      commit_preg[c]  = 6'($urandom_range(0, 63));
    end
    for (int i = 0; i < RP; i++) begin
      psrc1[i] = ($urandom_range(0, 2) == 0) ? wb_preg[$urandom_range(0, 3)] : 6'($urandom_range(0, 63));
      psrc2[i] = ($urandom_range(0, 2) == 0) ? wb_preg[$urandom_range(0, 3)] : 6'($urandom_range(0, 63));
      src1[i]  = ($urandom_range(0, 2) == 0) ? commit_areg[$urandom_range(0, 3)] : 5'($urandom_range(0, 31));
      src2[i]  = ($urandom_range(0, 2) == 0) ? commit_areg[$urandom_range(0, 3)] : 5'($urandom_range(0, 31));
    end
  endtask

  task automatic chk64(input string nm, input int port, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", nm, port, act, exp);
    end
  endtask

  // Monitor: outputs are valid mid-cycle; pop one expectation per cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      for (int i = 0; i < RP; i++) begin
        chk64("arf1", i, arf1[i], e.a1[i]);
        chk64("arf2", i, arf2[i], e.a2[i]);
        chk64("prf1", i, prf1[i], e.p1[i]);
        chk64("prf2", i, prf2[i], e.p2[i]);
        chk64("prdy1", i, {63'd0, prdy1[i]}, {63'd0, e.r1[i]});
        chk64("prdy2", i, {63'd0, prdy2[i]}, {63'd0, e.r2[i]});
      end
    end
  end

  initial begin
    clear_model();
    idle();
    reset = 1'b1;
    @(posedge clk);
    apply_edge();
    #1;

    // Reset state reads.
    idle(); psrc1[0] = 6'd5; src1[0] = 5'd3; step();

    // Writeback bypass, then the same read from storage.
    idle(); wb_valid[0] = 1'b1; wb_preg[0] = 6'd7; wb_data[0] = 64'hDEAD; psrc2[3] = 6'd7; step();
    idle(); psrc2[3] = 6'd7; step();

    // Two commits to areg 4; the younger one's source is written this cycle.
    idle(); wb_valid[0] = 1'b1; wb_preg[0] = 6'd9; wb_data[0] = 64'h11; step();
    idle();
    commit_valid = 4'b0011;
    commit_areg[0] = 5'd4; commit_preg[0] = 6'd9;
    commit_areg[1] = 5'd4; commit_preg[1] = 6'd12;
    wb_valid[0] = 1'b1; wb_preg[0] = 6'd12; wb_data[0] = 64'h22;
    src1[0] = 5'd4; step();
    idle(); src1[0] = 5'd4; step();

    // Commit to x0 is ignored.
    idle(); commit_valid[0] = 1'b1; commit_areg[0] = 5'd0; commit_preg[0] = 6'd9; src1[1] = 5'd0; step();
    idle(); src1[1] = 5'd0; step();

    // Allocation clears ready, keeps data; flush discards writeback ready.
    idle(); alloc_valid[0] = 1'b1; alloc_preg[0] = 6'd7; psrc1[2] = 6'd7; step();
    idle(); psrc1[2] = 6'd7; step();
    idle(); flush = 1'b1; wb_valid[1] = 1'b1; wb_preg[1] = 6'd20; wb_data[1] = 64'hCAFE_F00D; psrc1[4] = 6'd20; step();
    idle(); psrc1[4] = 6'd20; step();

    // Reset discards same-cycle writeback and commit.
    idle(); reset = 1'b1; wb_valid[0] = 1'b1; wb_preg[0] = 6'd3; wb_data[0] = 64'h33;
    commit_valid[0] = 1'b1; commit_areg[0] = 5'd5; commit_preg[0] = 6'd3; step();
    idle(); psrc1[0] = 6'd3; src1[0] = 5'd5; step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      step();
    end
    idle();

    // Drain: the monitor gets a bounded number of cycles to consume all.
    for (int t = 0; t < 4 && sb_q.size() > 0; t++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
